// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg : shared widths, capture FSM states and |x| saturation helper
// Rev 1.0
// ============================================================================
package fir_pkg;

   localparam int FIR_IN_W  = 17;
   localparam int FIR_OUT_W = 40;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SKIP    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DRAIN   = 2'd3
   } cap_state_e;

   // The most negative value has no positive twin, so it saturates to max positive.
   function automatic logic [FIR_OUT_W-1:0] abs_sat(input logic signed [FIR_OUT_W-1:0] x);
      logic [FIR_OUT_W-1:0] r;
      if (x == {1'b1, {(FIR_OUT_W-1){1'b0}}})
         r = {1'b0, {(FIR_OUT_W-1){1'b1}}};
      else if (x[FIR_OUT_W-1])
         r = -x;
      else
         r = x;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_capture_ram.sv
`default_nettype none
// ============================================================================
// fir_capture_ram : DEPTH x DW buffer, one write port, one registered read port
// Rev 1.0
// ============================================================================
module fir_capture_ram #(
   parameter int DW    = 40,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we)
         mem_q[waddr] <= wdata;
   end

   // Output register only loads on a read, so it holds the word while stalled.
   always_ff @(posedge clk) begin
      if (rst)
         rdata_q <= '0;
      else if (re)
         rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fir_result_capture.sv
`default_nettype none
// ============================================================================
// fir_result_capture : skip FIR latency, capture output words, drain over valid/ready
// Rev 1.0
// ============================================================================
module fir_result_capture
   import fir_pkg::*;
#(
   parameter int DW    = FIR_OUT_W,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic                 clock95,
   input  logic                 reset95,
   input  logic                 arm95,
   input  logic [7:0]           skip95,
   input  logic [AW:0]          count95,
   input  logic                 in_valid95,
   input  logic signed [DW-1:0] filter_output95,
   output logic signed [DW-1:0] rd_data95,
   output logic                 rd_valid95,
   input  logic                 rd_ready95,
   output logic                 busy95,
   output logic                 done95,
   output logic [DW-1:0]        peak95
);

   cap_state_e    state_q, state_d;
   logic [7:0]    skip_q, skip_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]   xfer_q, xfer_d;
   logic          rd_valid_q, rd_valid_d;
   logic          done_q, done_d;
   logic [DW-1:0] peak_q, peak_d;

   logic          ram_we;
   logic          ram_re;
   logic          advance;
   logic [AW:0]   count_clamped;
   logic [DW-1:0] sample_abs;
   logic [DW-1:0] ram_rdata;

   assign count_clamped = (count95 > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : count95;
   assign sample_abs    = abs_sat(filter_output95);

   always_comb begin
      state_d    = state_q;
      skip_d     = skip_q;
      cnt_d      = cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      xfer_d     = xfer_q;
      rd_valid_d = rd_valid_q;
      done_d     = 1'b0;
      peak_d     = peak_q;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
      advance    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arm95) begin
               skip_d   = skip95;
               cnt_d    = count_clamped;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               xfer_d   = '0;
               peak_d   = '0;
               if (count_clamped == '0)
                  done_d = 1'b1;
               else if (skip95 == 8'd0)
                  state_d = ST_CAPTURE;
               else
                  state_d = ST_SKIP;
            end
         end
         ST_SKIP: begin
            if (in_valid95) begin
               skip_d = skip_q - 8'd1;
               if (skip_q == 8'd1)
                  state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (in_valid95) begin
               ram_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (sample_abs > peak_q)
                  peak_d = sample_abs;
               if (wr_ptr_q + 1'b1 == cnt_q)
                  state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The RAM output register refills whenever it is empty or being taken,
            // which keeps back-to-back transfers at one word per cycle.
            advance = !rd_valid_q || rd_ready95;
            if (advance) begin
               if (rd_ptr_q != cnt_q) begin
                  ram_re     = 1'b1;
                  rd_ptr_d   = rd_ptr_q + 1'b1;
                  rd_valid_d = 1'b1;
               end else begin
                  rd_valid_d = 1'b0;
               end
            end
            if (rd_valid_q && rd_ready95) begin
               xfer_d = xfer_q + 1'b1;
               if (xfer_q + 1'b1 == cnt_q) begin
                  rd_valid_d = 1'b0;
                  done_d     = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock95) begin
      if (reset95) begin
         state_q    <= ST_IDLE;
         skip_q     <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         xfer_q     <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         peak_q     <= '0;
      end else begin
         state_q    <= state_d;
         skip_q     <= skip_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         xfer_q     <= xfer_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         peak_q     <= peak_d;
      end
   end

   fir_capture_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clock95),
      .rst   (reset95),
      .we    (ram_we),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (filter_output95),
      .re    (ram_re),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (ram_rdata)
   );

   assign rd_data95  = ram_rdata;
   assign rd_valid95 = rd_valid_q;
   assign busy95     = (state_q != ST_IDLE);
   assign done95     = done_q;
   assign peak95     = peak_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_result_capture.sv
`default_nettype none
// ============================================================================
// tb_fir_result_capture : directed stimulus against a sample-window model
// Rev 1.0
// ============================================================================
module tb_fir_result_capture;

   localparam int     DW    = 40;
   localparam int     DEPTH = 256;
   localparam int     AW    = 8;
   localparam longint MAXP  = (64'sd1 <<< (DW-1)) - 64'sd1;
   localparam longint MINV  = -(64'sd1 <<< (DW-1));

   logic                 clock95 = 1'b0;
   logic                 reset95 = 1'b1;
   logic                 arm95 = 1'b0;
   logic [7:0]           skip95 = '0;
   logic [AW:0]          count95 = '0;
   logic                 in_valid95 = 1'b0;
   logic signed [DW-1:0] filter_output95 = '0;
   logic signed [DW-1:0] rd_data95;
   logic                 rd_valid95;
   logic                 rd_ready95 = 1'b0;
   logic                 busy95;
   logic                 done95;
   logic [DW-1:0]        peak95;

   always #5 clock95 = ~clock95;

   fir_result_capture #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .clock95         (clock95),
      .reset95         (reset95),
      .arm95           (arm95),
      .skip95          (skip95),
      .count95         (count95),
      .in_valid95      (in_valid95),
      .filter_output95 (filter_output95),
      .rd_data95       (rd_data95),
      .rd_valid95      (rd_valid95),
      .rd_ready95      (rd_ready95),
      .busy95          (busy95),
      .done95          (done95),
      .peak95          (peak95)
   );

   int     n_checks = 0;
   int     n_fail   = 0;
   int     done_cnt = 0;
   int     cyc      = 0;
   longint exp_q[$];
   longint got_q[$];
   int     xfer_cyc[$];
   longint exp_peak = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected drain = fed samples [skip, skip+min(count,DEPTH)); peak = max saturated |x|.
   function automatic void model(input int skip, input int count, input longint s[$]);
      int n = (count > DEPTH) ? DEPTH : count;
      exp_peak = 0;
      for (int i = skip; i < skip + n && i < s.size(); i++) begin
         longint a = (s[i] < 0) ? -s[i] : s[i];
         if (a > MAXP) a = MAXP;
         exp_q.push_back(s[i]);
         if (a > exp_peak) exp_peak = a;
      end
   endfunction

   // Single compare process: ordering, stall stability, done only after full drain.
   initial begin
      bit     prev_valid = 0;
      bit     prev_ready = 0;
      longint prev_data  = 0;
      forever begin
         @(negedge clock95);
         cyc++;
         if (reset95) begin
            prev_valid = 0;
         end else begin
            if (prev_valid && !prev_ready) begin
               check("stall_valid", rd_valid95, 1);
               check("stall_data", rd_data95, prev_data);
            end
            if (rd_valid95 && rd_ready95) begin
               got_q.push_back(rd_data95);
               xfer_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL extra_word: got %0d expected no transfer", longint'(rd_data95));
               end else begin
                  check("rd_data", rd_data95, exp_q.pop_front());
               end
            end
            if (done95) begin
               done_cnt++;
               check("done_after_drain", exp_q.size(), 0);
            end
            prev_valid = rd_valid95;
            prev_ready = rd_ready95;
            prev_data  = rd_data95;
         end
      end
   end

   task automatic arm(input int skip, input int count);
      arm95   = 1'b1;
      skip95  = 8'(skip);
      count95 = (AW+1)'(count);
      @(posedge clock95); #1;
      arm95   = 1'b0;
   endtask

   task automatic feed(input longint s[$]);
      foreach (s[i]) begin
         in_valid95      = 1'b1;
         filter_output95 = DW'(s[i]);
         @(posedge clock95); #1;
      end
      in_valid95 = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int start = done_cnt;
      int k = 0;
      while (done_cnt == start && k < budget) begin
         @(posedge clock95); #1;
         k++;
      end
      check(name, done_cnt - start, 1);
   endtask

   task automatic pulse_reset(input string name);
      int d0 = done_cnt;
      reset95 = 1'b1;
      @(posedge clock95); #1;
      reset95 = 1'b0;
      exp_q.delete();
      check({name, "_rd_valid"}, rd_valid95, 0);
      check({name, "_busy"}, busy95, 0);
      check({name, "_done"}, done95, 0);
      check({name, "_rd_data"}, rd_data95, 0);
      check({name, "_peak"}, peak95, 0);
      repeat (2) @(posedge clock95);
      #1;
      check({name, "_no_done"}, done_cnt, d0);
   endtask

   task automatic wait_rd_valid(input string name);
      int k = 0;
      while (!rd_valid95 && k < 20) begin
         @(posedge clock95); #1;
         k++;
      end
      check(name, rd_valid95, 1);
   endtask

   initial begin
      longint t1[8] = '{-2, 0, -2, 0, -2, -1, -1, -2};
      longint t4[8] = '{10, -11, 12, -13, 14, -15, 16, -17};
      longint v[$];
      int     d0;

      // Reset state
      repeat (3) @(posedge clock95);
      #1;
      check("rst_rd_valid", rd_valid95, 0);
      check("rst_busy", busy95, 0);
      check("rst_done", done95, 0);
      check("rst_rd_data", rd_data95, 0);
      check("rst_peak", peak95, 0);
      reset95 = 1'b0;
      @(posedge clock95); #1;

      // 1: skip 3, capture 4
      v.delete();
      for (int i = 0; i < 8; i++) v.push_back(t1[i]);
      got_q.delete();
      rd_ready95 = 1'b1;
      model(3, 4, v);
      d0 = done_cnt;
      arm(3, 4);
      check("t1_busy", busy95, 1);
      feed(v);
      wait_done("t1_done", 50);
      check("t1_peak", peak95, exp_peak);
      check("t1_peak_lit", peak95, 2);
      check("t1_nwords", got_q.size(), 4);
      if (got_q.size() == 4) begin
         check("t1_w0", got_q[0], 0);
         check("t1_w1", got_q[1], -2);
         check("t1_w2", got_q[2], -1);
         check("t1_w3", got_q[3], -1);
      end
      repeat (3) @(posedge clock95);
      #1;
      check("t1_one_done", done_cnt - d0, 1);
      check("t1_idle", busy95, 0);

      // 2: count 0
      d0 = done_cnt;
      arm(0, 0);
      check("t2_done_pulse", done95, 1);
      check("t2_busy", busy95, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock95); #1;
         check("t2_busy_low", busy95, 0);
         check("t2_no_valid", rd_valid95, 0);
      end
      check("t2_done_cnt", done_cnt - d0, 1);

      // 3: clamp 300 -> 256, ramp, full-rate drain
      v.delete();
      for (int i = 0; i < 300; i++) v.push_back(longint'(i));
      got_q.delete();
      xfer_cyc.delete();
      model(0, 300, v);
      arm(0, 300);
      feed(v);
      wait_done("t3_done", 400);
      check("t3_nwords", got_q.size(), 256);
      if (got_q.size() == 256) begin
         check("t3_first", got_q[0], 0);
         check("t3_last", got_q[255], 255);
         check("t3_rate", xfer_cyc[255] - xfer_cyc[0], 255);
      end
      check("t3_peak", peak95, exp_peak);
      check("t3_peak_lit", peak95, 255);

      // 4: stalled drain with ready toggling
      v.delete();
      for (int i = 0; i < 8; i++) v.push_back(t4[i]);
      got_q.delete();
      rd_ready95 = 1'b0;
      model(1, 6, v);
      arm(1, 6);
      feed(v);
      d0 = done_cnt;
      for (int k = 0; k < 60 && done_cnt == d0; k++) begin
         rd_ready95 = ~rd_ready95;
         @(posedge clock95); #1;
      end
      check("t4_done", done_cnt - d0, 1);
      check("t4_nwords", got_q.size(), 6);
      if (got_q.size() == 6) begin
         check("t4_w0", got_q[0], -11);
         check("t4_w5", got_q[5], 16);
      end
      check("t4_peak", peak95, exp_peak);
      rd_ready95 = 1'b1;

      // 5: most negative sample
      v.delete();
      v.push_back(MINV);
      v.push_back(5);
      got_q.delete();
      model(0, 2, v);
      arm(0, 2);
      feed(v);
      wait_done("t5_done", 30);
      if (got_q.size() == 2) check("t5_min_exact", got_q[0], MINV);
      else check("t5_nwords", got_q.size(), 2);
      check("t5_peak", peak95, 64'd549755813887);

      // 6: resets mid-capture and mid-drain, arm ignored in drain
      v.delete();
      for (int i = 0; i < 3; i++) v.push_back(longint'(100 + i));
      arm(0, 10);
      feed(v);
      pulse_reset("t6_cap_rst");

      got_q.delete();
      v.delete();
      for (int i = 0; i < 4; i++) v.push_back(longint'(-7 * (i + 1)));
      rd_ready95 = 1'b0;
      model(0, 4, v);
      arm(0, 4);
      feed(v);
      wait_rd_valid("t6_valid");
      d0 = done_cnt;
      arm(0, 0);
      check("t6_arm_ignored_done", done95, 0);
      check("t6_arm_ignored_busy", busy95, 1);
      check("t6_arm_ignored_valid", rd_valid95, 1);
      rd_ready95 = 1'b1;
      wait_done("t6_drain_done", 30);
      check("t6_nwords", got_q.size(), 4);
      check("t6_peak", peak95, 28);

      v.delete();
      for (int i = 0; i < 4; i++) v.push_back(longint'(55 + i));
      rd_ready95 = 1'b0;
      arm(0, 4);
      feed(v);
      wait_valid_then_reset: begin
         wait_rd_valid("t6_valid2");
         pulse_reset("t6_drn_rst");
      end

      got_q.delete();
      v.delete();
      for (int i = 0; i < 3; i++) v.push_back(longint'(3 - i));
      rd_ready95 = 1'b1;
      model(1, 2, v);
      arm(1, 2);
      feed(v);
      wait_done("t6_rearm_done", 30);
      check("t6_rearm_nwords", got_q.size(), 2);
      check("t6_rearm_peak", peak95, 2);

      repeat (3) @(posedge clock95);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
